// File: rtl/gfx_pkg.sv
// Shared graphics definitions for the 96x64 RGB565 OLED pipeline.
// Screen geometry, bus widths and the per-pixel position payload.
package gfx_pkg;

  localparam int unsigned SCREEN_W   = 96;
  localparam int unsigned SCREEN_H   = 64;
  localparam int unsigned NUM_PIXELS = SCREEN_W * SCREEN_H;
  localparam int unsigned PIX_IDX_W  = 13;
  localparam int unsigned RGB565_W   = 16;
  // Row of an out-of-screen 13-bit index reaches 85, so 7 bits cover x and y
  localparam int unsigned COORD_W    = 7;

  localparam logic [RGB565_W-1:0] COLOUR_TRANSPARENT = 16'h0000;

  typedef struct packed {
    logic                 valid;
    logic [PIX_IDX_W-1:0] idx;
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
  } pix_pos_t;

endpackage

// File: rtl/pixel_xy_split.sv
// Registered split of a row-major pixel index into (x, y) screen coordinates.
// The constant divide sits in front of a register so downstream stages see it timed.
module pixel_xy_split
  import gfx_pkg::*;
#(
  parameter int unsigned W = SCREEN_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PIX_IDX_W-1:0] pixel_index,
  input  logic                 pix_valid,
  output pix_pos_t             pos
);

  logic [PIX_IDX_W-1:0] row;
  logic [PIX_IDX_W-1:0] col;

  always_comb begin
    row = pixel_index / PIX_IDX_W'(W);
    col = pixel_index - PIX_IDX_W'(row * PIX_IDX_W'(W));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos <= '0;
    end else begin
      pos.valid <= pix_valid;
      pos.idx   <= pixel_index;
      pos.x     <= COORD_W'(col);
      pos.y     <= COORD_W'(row);
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// Offsets/mirrors a screen-authored sprite, composites it over the background and
// counts opaque pixels per frame. Three-stage pipeline: xy split, ROM address, blend.
module sprite_compositor
  import gfx_pkg::*;
#(
  parameter int unsigned          WIDTH       = SCREEN_W,
  parameter int unsigned          HEIGHT      = SCREEN_H,
  parameter logic [RGB565_W-1:0]  TRANSPARENT = COLOUR_TRANSPARENT,
  parameter int unsigned          MIRROR_SUM  = 99,
  parameter int unsigned          OFF_W       = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PIX_IDX_W-1:0]        pixel_index,
  input  logic                        pix_valid,
  input  logic signed [OFF_W-1:0]     dx,
  input  logic signed [OFF_W-1:0]     dy,
  input  logic                        flip,
  output logic [PIX_IDX_W-1:0]        rom_index,
  input  logic [RGB565_W-1:0]         rom_colour,
  output logic [PIX_IDX_W-1:0]        bg_index,
  input  logic [RGB565_W-1:0]         bg_colour,
  output logic [RGB565_W-1:0]         oled_colour,
  output logic                        out_valid,
  output logic                        opaque,
  output logic [PIX_IDX_W-1:0]        frame_opaque_cnt
);

  // Signed source-coordinate width: covers MIRROR_SUM/row span plus a full offset swing
  localparam int unsigned S_W = OFF_W + 3;

  pix_pos_t pos;

  logic signed [OFF_W-1:0] dx_s;
  logic signed [OFF_W-1:0] dy_s;
  logic                    flip_s;
  logic                    frame_start;

  logic signed [S_W-1:0]   x_s;
  logic signed [S_W-1:0]   y_s;
  logic signed [S_W-1:0]   dx_ext;
  logic signed [S_W-1:0]   dy_ext;
  logic signed [S_W-1:0]   col_s;
  logic signed [S_W-1:0]   sx;
  logic signed [S_W-1:0]   sy;
  logic                    in_rng;
  logic [PIX_IDX_W-1:0]    src_addr;

  logic                    s1_valid;
  logic                    s1_in_rng;
  logic                    op;
  logic                    s2_pix0;
  logic [PIX_IDX_W-1:0]    running;

  pixel_xy_split #(
    .W (WIDTH)
  ) u_xy (
    .clk         (clk),
    .reset       (reset),
    .pixel_index (pixel_index),
    .pix_valid   (pix_valid),
    .pos         (pos)
  );

  // Offsets are latched only at frame start so a whole frame renders with one set
  assign frame_start = pix_valid && (pixel_index == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dx_s   <= '0;
      dy_s   <= '0;
      flip_s <= 1'b0;
    end else if (frame_start) begin
      dx_s   <= dx;
      dy_s   <= dy;
      flip_s <= flip;
    end
  end

  // Screen position -> sprite source position, rejecting anything off the sprite canvas
  always_comb begin
    x_s      = signed'(S_W'(pos.x));
    y_s      = signed'(S_W'(pos.y));
    dx_ext   = signed'({{(S_W-OFF_W){dx_s[OFF_W-1]}}, dx_s});
    dy_ext   = signed'({{(S_W-OFF_W){dy_s[OFF_W-1]}}, dy_s});
    col_s    = flip_s ? (signed'(S_W'(MIRROR_SUM)) - x_s) : x_s;
    sx       = col_s - dx_ext;
    sy       = y_s - dy_ext;
    in_rng   = !sx[S_W-1] && (sx < signed'(S_W'(WIDTH))) &&
               !sy[S_W-1] && (sy < signed'(S_W'(HEIGHT)));
    src_addr = PIX_IDX_W'(sy) * PIX_IDX_W'(WIDTH) + PIX_IDX_W'(sx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_index <= '0;
      bg_index  <= '0;
      s1_valid  <= 1'b0;
      s1_in_rng <= 1'b0;
    end else begin
      rom_index <= in_rng ? src_addr : '0;
      bg_index  <= pos.idx;
      s1_valid  <= pos.valid;
      s1_in_rng <= in_rng;
    end
  end

  // Blend stage: ROM data for rom_index is valid during this cycle
  assign op      = s1_in_rng && (rom_colour != TRANSPARENT);
  assign s2_pix0 = s1_valid && (bg_index == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oled_colour <= '0;
      opaque      <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      oled_colour <= op ? rom_colour : bg_colour;
      opaque      <= op;
      out_valid   <= s1_valid;
    end
  end

  // Per-frame opaque count, published as pixel 0 of the next frame leaves the blend stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running          <= '0;
      frame_opaque_cnt <= '0;
    end else if (s2_pix0) begin
      frame_opaque_cnt <= running;
      running          <= PIX_IDX_W'(op);
    end else if (s1_valid && op) begin
      running <= running + PIX_IDX_W'(1);
    end
  end

endmodule
